// File: rtl/card_pkg.sv
// Card types, rank constants and the rank-to-baccarat-value helper shared by
// the hand datapath, its score sub-module and the handshake interface.
package card_pkg;

  typedef logic [3:0] card_t;
  typedef logic [3:0] score_t;

  localparam card_t RANK_ACE  = 4'd1;
  localparam card_t RANK_KING = 4'd13;

  // Ranks 1..9 count at face value; tens, faces and the empty slot (0) count as 0.
  function automatic score_t card_value(input card_t c);
    if ((c >= 4'd1) && (c <= 4'd9)) begin
      return score_t'(c);
    end else begin
      return 4'd0;
    end
  endfunction

endpackage

// File: rtl/hand_datapath_if.sv
// Handshake/bus bundle between the round controller (master) and the
// card-dealing datapath (slave): load pulses one way, cards/scores/status back.
interface hand_datapath_if;

  logic             load_pcard1;
  logic             load_pcard2;
  logic             load_pcard3;
  logic             load_dcard1;
  logic             load_dcard2;
  logic             load_dcard3;
  card_pkg::card_t  new_card;
  card_pkg::card_t  pcard1;
  card_pkg::card_t  pcard2;
  card_pkg::card_t  pcard3;
  card_pkg::card_t  dcard1;
  card_pkg::card_t  dcard2;
  card_pkg::card_t  dcard3;
  card_pkg::score_t pscore;
  card_pkg::score_t dscore;
  logic [2:0]       cards_dealt;
  logic             seq_error;

  modport master (
    output load_pcard1, load_pcard2, load_pcard3,
           load_dcard1, load_dcard2, load_dcard3,
    input  new_card, pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
           pscore, dscore, cards_dealt, seq_error
  );

  modport slave (
    input  load_pcard1, load_pcard2, load_pcard3,
           load_dcard1, load_dcard2, load_dcard3,
    output new_card, pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
           pscore, dscore, cards_dealt, seq_error
  );

endinterface

// File: rtl/hand_datapath_score_hand.sv
// score_hand: combinational baccarat score of a three-card hand,
// (sum of card values) mod 10. The sum needs 5 bits (max 9+9+9 = 27).
module score_hand
  import card_pkg::*;
(
  input  card_t  i_card1,
  input  card_t  i_card2,
  input  card_t  i_card3,
  output score_t o_score
);

  logic [4:0] w_sum;

  // Add the three card values and reduce modulo 10.
  always_comb begin
    w_sum   = {1'b0, card_value(i_card1)} + {1'b0, card_value(i_card2)}
            + {1'b0, card_value(i_card3)};
    o_score = score_t'(w_sum % 5'd10);
  end

endmodule

// File: rtl/hand_datapath.sv
// hand_datapath: card source, six hand slots, load decode, deal counter and
// sticky protocol-error flag for the baccarat round controller.
// Build option: define CARD_LFSR_EN to replace the 1..13 wrap counter with an
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4) seeded by LFSR_SEED.
module hand_datapath
  import card_pkg::*;
#(
  parameter int NUM_RANKS = 13
`ifdef CARD_LFSR_EN
  ,
  parameter logic [7:0] LFSR_SEED = 8'hA5
`endif
) (
  input  logic             slow_clock,
  input  logic             reset,
  hand_datapath_if.slave   bus
);

  card_t      w_new_card;
  card_t      r_slot [6];
  logic [5:0] w_load;
  logic [2:0] w_num_loads;
  logic       w_target_empty;
  logic       w_load_ok;
  logic       w_violation;
  logic [2:0] r_cards_dealt;
  logic       r_seq_error;

`ifdef CARD_LFSR_EN
  logic [7:0] r_lfsr;

  // Free-running LFSR; shifts every non-reset edge regardless of loads.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_new_card = card_t'((r_lfsr % 8'(NUM_RANKS)) + 8'd1);
`else
  card_t r_card_cnt;

  // Wrap counter 1..NUM_RANKS; advances every non-reset edge regardless of loads.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      r_card_cnt <= RANK_ACE;
    end else if (r_card_cnt >= 4'(NUM_RANKS)) begin
      r_card_cnt <= RANK_ACE;
    end else begin
      r_card_cnt <= r_card_cnt + 4'd1;
    end
  end

  assign w_new_card = r_card_cnt;
`endif

  assign w_load = {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
                   bus.load_pcard3, bus.load_pcard2, bus.load_pcard1};

  // Count simultaneous loads and check whether the addressed slot is empty.
  always_comb begin
    w_num_loads    = 3'd0;
    w_target_empty = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w_num_loads = w_num_loads + {2'b00, w_load[i]};
      if (w_load[i] && (r_slot[i] == 4'd0)) begin
        w_target_empty = 1'b1;
      end else begin
        w_target_empty = w_target_empty;
      end
    end
    w_load_ok   = (w_num_loads == 3'd1) && w_target_empty;
    w_violation = (w_num_loads > 3'd1) || ((w_num_loads == 3'd1) && !w_target_empty);
  end

  // Hand slots: only a clean single load into an empty slot writes it.
  always_ff @(posedge slow_clock) begin
    for (int i = 0; i < 6; i++) begin
      if (reset) begin
        r_slot[i] <= 4'd0;
      end else if (w_load_ok && w_load[i]) begin
        r_slot[i] <= w_new_card;
      end else begin
        r_slot[i] <= r_slot[i];
      end
    end
  end

  // Deal counter (saturating at 6) and sticky violation flag.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      r_cards_dealt <= 3'd0;
      r_seq_error   <= 1'b0;
    end else begin
      if (w_load_ok && (r_cards_dealt != 3'd6)) begin
        r_cards_dealt <= r_cards_dealt + 3'd1;
      end else begin
        r_cards_dealt <= r_cards_dealt;
      end
      r_seq_error <= r_seq_error | w_violation;
    end
  end

  score_hand u_player_score (
    .i_card1 (r_slot[0]),
    .i_card2 (r_slot[1]),
    .i_card3 (r_slot[2]),
    .o_score (bus.pscore)
  );

  score_hand u_dealer_score (
    .i_card1 (r_slot[3]),
    .i_card2 (r_slot[4]),
    .i_card3 (r_slot[5]),
    .o_score (bus.dscore)
  );

  assign bus.new_card    = w_new_card;
  assign bus.pcard1      = r_slot[0];
  assign bus.pcard2      = r_slot[1];
  assign bus.pcard3      = r_slot[2];
  assign bus.dcard1      = r_slot[3];
  assign bus.dcard2      = r_slot[4];
  assign bus.dcard3      = r_slot[5];
  assign bus.cards_dealt = r_cards_dealt;
  assign bus.seq_error   = r_seq_error;

endmodule
